// File: rtl/apb_wdt_multi.sv
// Multi-channel APB watchdog with a shared prescaler, write lock and kick key.
// Each channel counts down on prescaler ticks; the first timeout raises OV
// (and IRQ when enabled), a timeout while OV is still set raises RSTFLG and,
// when enabled, the sticky system reset request.
// Ports:
//   i_pclk, i_preset      clock, asynchronous active-high reset
//   i_psel .. i_pwdata    APB slave request (word address i_paddr[7:2])
//   o_prdata              combinational read data
//   o_pready              always 1, no wait states
//   o_irq[CH-1:0]         per-channel interrupt (OV & IRQEN)
//   o_rst_req             sticky reset request, cleared only by i_preset
module apb_wdt_multi #(
  parameter int unsigned CH = 2,
  parameter int unsigned CW = 32,
  parameter int unsigned PW = 16
) (
  input  logic          i_pclk,
  input  logic          i_preset,
  input  logic          i_psel,
  input  logic [7:2]    i_paddr,
  input  logic          i_penable,
  input  logic          i_pwrite,
  input  logic [31:0]   i_pwdata,
  output logic [31:0]   o_prdata,
  output logic          o_pready,
  output logic [CH-1:0] o_irq,
  output logic          o_rst_req
);

  localparam logic [31:0] KICK_KEY   = 32'h5A5A_A5A5;
  localparam logic [31:0] UNLOCK_KEY = 32'h1ACC_E551;
  localparam logic [31:0] UNMAPPED   = 32'hDEAD_BEEF;

  // Word offsets inside a channel block
  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_LOAD   = 3'd1;
  localparam logic [2:0] REG_VALUE  = 3'd2;
  localparam logic [2:0] REG_STATUS = 3'd3;
  localparam logic [2:0] REG_KICK   = 3'd4;

  logic          w_wr;
  logic          w_rd;
  logic          w_tick;
  logic          w_wr_presc;
  logic          w_wr_lock;
  logic [PW-1:0] r_presc;
  logic [PW-1:0] r_pcnt;
  logic          r_locked;
  logic          r_rst_req;
  logic [CH-1:0] w_rq_set;
  logic [31:0]   w_ch_rd [CH];

  assign w_wr       = i_psel & i_pwrite & i_penable;
  assign w_rd       = i_psel & ~i_pwrite;
  assign w_wr_presc = w_wr & (i_paddr == 6'h20) & ~r_locked;
  assign w_wr_lock  = w_wr & (i_paddr == 6'h21);
  assign w_tick     = (r_pcnt == r_presc);
  assign o_pready   = 1'b1;
  assign o_rst_req  = r_rst_req;

  // Shared prescaler, lock and sticky reset request
  always_ff @(posedge i_pclk or posedge i_preset) begin
    if (i_preset) begin
      r_presc   <= '0;
      r_pcnt    <= '0;
      r_locked  <= 1'b0;
      r_rst_req <= 1'b0;
    end else begin
      if (w_wr_presc) r_presc <= i_pwdata[PW-1:0];
      if (w_wr_presc || w_tick) r_pcnt <= '0;
      else                      r_pcnt <= r_pcnt + PW'(1);
      if (w_wr_lock) r_locked <= (i_pwdata != UNLOCK_KEY);
      if (|w_rq_set) r_rst_req <= 1'b1;
    end
  end

  for (genvar n = 0; n < CH; n++) begin : g_ch
    logic [2:0]    r_ctrl;
    logic [CW-1:0] r_load;
    logic [CW-1:0] r_value;
    logic          r_ov;
    logic          r_rstflg;
    logic          w_sel;
    logic          w_wr_ctrl;
    logic          w_wr_load;
    logic          w_kick;
    logic          w_w1c;
    logic          w_en;
    logic          w_timeout;
    logic          w_reload;
    logic [31:0]   w_rdata;

    assign w_sel     = ~i_paddr[7] & (i_paddr[6:5] == 2'(n));
    assign w_wr_ctrl = w_wr & w_sel & (i_paddr[4:2] == REG_CTRL) & ~r_locked;
    assign w_wr_load = w_wr & w_sel & (i_paddr[4:2] == REG_LOAD) & ~r_locked;
    assign w_kick    = w_wr & w_sel & (i_paddr[4:2] == REG_KICK) & (i_pwdata == KICK_KEY);
    assign w_w1c     = w_wr & w_sel & (i_paddr[4:2] == REG_STATUS) & i_pwdata[0];
    assign w_en      = r_ctrl[0];
    // A valid kick in the same cycle suppresses the timeout entirely
    assign w_timeout = w_tick & w_en & (r_value == '0) & ~w_kick;
    assign w_reload  = w_kick | w_timeout | (w_wr_ctrl & i_pwdata[0] & ~w_en);

    assign w_rq_set[n] = w_timeout & r_ov & r_ctrl[2];
    assign o_irq[n]    = r_ov & r_ctrl[1];
    assign w_ch_rd[n]  = w_rdata;

    // Channel registers and down-counter
    always_ff @(posedge i_pclk or posedge i_preset) begin
      if (i_preset) begin
        r_ctrl   <= '0;
        r_load   <= '1;
        r_value  <= '0;
        r_ov     <= 1'b0;
        r_rstflg <= 1'b0;
      end else begin
        if (w_wr_ctrl) r_ctrl <= i_pwdata[2:0];
        if (w_wr_load) r_load <= i_pwdata[CW-1:0];
        if (w_reload)               r_value <= r_load;
        else if (w_tick && w_en)    r_value <= r_value - CW'(1);
        // A first timeout beats a simultaneous W1C
        r_ov <= (r_ov & ~w_w1c) | (w_timeout & ~r_ov);
        if (w_timeout && r_ov) r_rstflg <= 1'b1;
      end
    end

    // Channel read data
    always_comb begin
      w_rdata = UNMAPPED;
      case (i_paddr[4:2])
        REG_CTRL:   w_rdata = {29'b0, r_ctrl};
        REG_LOAD:   w_rdata = 32'(r_load);
        REG_VALUE:  w_rdata = 32'(r_value);
        REG_STATUS: w_rdata = {30'b0, r_rstflg, r_ov};
        REG_KICK:   w_rdata = 32'h0;
        default:    w_rdata = UNMAPPED;
      endcase
    end
  end

  // Read decode; channels beyond CH and unused offsets return UNMAPPED
  always_comb begin
    o_prdata = 32'h0;
    if (w_rd) begin
      o_prdata = UNMAPPED;
      if (i_paddr[7]) begin
        if (i_paddr[6:2] == 5'd0)      o_prdata = 32'(r_presc);
        else if (i_paddr[6:2] == 5'd1) o_prdata = {31'b0, r_locked};
      end else begin
        for (int n = 0; n < CH; n++) begin
          if (i_paddr[6:5] == 2'(n)) o_prdata = w_ch_rd[n];
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_wdt_multi.sv
// Directed bench for apb_wdt_multi (CH=2, CW=32, PW=16).
module tb_apb_wdt_multi;

  localparam logic [7:2] A_CTRL0   = 6'h00;
  localparam logic [7:2] A_LOAD0   = 6'h01;
  localparam logic [7:2] A_VALUE0  = 6'h02;
  localparam logic [7:2] A_STATUS0 = 6'h03;
  localparam logic [7:2] A_KICK0   = 6'h04;
  localparam logic [7:2] A_GAP0    = 6'h05;
  localparam logic [7:2] A_CTRL1   = 6'h08;
  localparam logic [7:2] A_LOAD1   = 6'h09;
  localparam logic [7:2] A_CTRL3   = 6'h18;
  localparam logic [7:2] A_PRESC   = 6'h20;
  localparam logic [7:2] A_LOCK    = 6'h21;
  localparam logic [7:2] A_GLBGAP  = 6'h22;
  localparam logic [31:0] KEY      = 32'h5A5AA5A5;
  localparam logic [31:0] UNLOCK   = 32'h1ACCE551;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psel = 1'b0;
  logic [7:2]  paddr = '0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready;
  logic [1:0]  irq;
  logic        rst_req;

  int n_vec = 0;
  int n_err = 0;

  apb_wdt_multi #(.CH(2), .CW(32), .PW(16)) dut (
    .i_pclk(clk), .i_preset(rst), .i_psel(psel), .i_paddr(paddr),
    .i_penable(penable), .i_pwrite(pwrite), .i_pwdata(pwdata),
    .o_prdata(prdata), .o_pready(pready), .o_irq(irq), .o_rst_req(rst_req)
  );

  always #50 clk = ~clk;

  // Called at a falling edge; the write lands on the second rising edge.
  task automatic wr(input logic [7:2] a, input logic [31:0] d);
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  // Zero-cycle peek: read decode is combinational.
  task automatic rd(input logic [7:2] a, output logic [31:0] d);
    psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
    #1;
    d = prdata;
    psel = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    rd(A_CTRL0, d);   n_vec++; if (d !== 32'h0)        begin n_err++; $display("FAIL rst_ctrl0 got=%h exp=%h", d, 32'h0); end
    rd(A_LOAD0, d);   n_vec++; if (d !== 32'hFFFFFFFF) begin n_err++; $display("FAIL rst_load0 got=%h exp=%h", d, 32'hFFFFFFFF); end
    rd(A_VALUE0, d);  n_vec++; if (d !== 32'h0)        begin n_err++; $display("FAIL rst_value0 got=%h exp=%h", d, 32'h0); end
    rd(A_STATUS0, d); n_vec++; if (d !== 32'h0)        begin n_err++; $display("FAIL rst_status0 got=%h exp=%h", d, 32'h0); end
    rd(A_CTRL1, d);   n_vec++; if (d !== 32'h0)        begin n_err++; $display("FAIL rst_ctrl1 got=%h exp=%h", d, 32'h0); end
    rd(A_LOAD1, d);   n_vec++; if (d !== 32'hFFFFFFFF) begin n_err++; $display("FAIL rst_load1 got=%h exp=%h", d, 32'hFFFFFFFF); end
    rd(A_PRESC, d);   n_vec++; if (d !== 32'h0)        begin n_err++; $display("FAIL rst_presc got=%h exp=%h", d, 32'h0); end
    rd(A_LOCK, d);    n_vec++; if (d !== 32'h0)        begin n_err++; $display("FAIL rst_lock got=%h exp=%h", d, 32'h0); end
    rd(A_CTRL3, d);   n_vec++; if (d !== 32'hDEADBEEF) begin n_err++; $display("FAIL rst_unmapped_ch3 got=%h exp=%h", d, 32'hDEADBEEF); end
    rd(A_GAP0, d);    n_vec++; if (d !== 32'hDEADBEEF) begin n_err++; $display("FAIL rst_unmapped_0x14 got=%h exp=%h", d, 32'hDEADBEEF); end
    rd(A_GLBGAP, d);  n_vec++; if (d !== 32'hDEADBEEF) begin n_err++; $display("FAIL rst_unmapped_0x88 got=%h exp=%h", d, 32'hDEADBEEF); end
    rd(A_KICK0, d);   n_vec++; if (d !== 32'h0)        begin n_err++; $display("FAIL rst_kick_read got=%h exp=%h", d, 32'h0); end
    n_vec++; if (irq !== 2'b00)  begin n_err++; $display("FAIL rst_irq got=%b exp=%b", irq, 2'b00); end
    n_vec++; if (rst_req !== 1'b0) begin n_err++; $display("FAIL rst_rst_req got=%b exp=%b", rst_req, 1'b0); end
    n_vec++; if (pready !== 1'b1) begin n_err++; $display("FAIL pready got=%b exp=%b", pready, 1'b1); end
  endtask

  // PRESC write edge P0; ticks at P0+4k; EN rise at P0+2 loads 5.
  task automatic test_countdown();
    logic [31:0] d;
    wr(A_LOAD0, 32'd5);
    wr(A_PRESC, 32'd3);
    wr(A_CTRL0, 32'd3);
    rd(A_VALUE0, d);  n_vec++; if (d !== 32'd5) begin n_err++; $display("FAIL cd_value_loaded got=%h exp=%h", d, 32'd5); end
    cyc(2);
    rd(A_VALUE0, d);  n_vec++; if (d !== 32'd4) begin n_err++; $display("FAIL cd_first_tick got=%h exp=%h", d, 32'd4); end
    cyc(19);
    rd(A_VALUE0, d);  n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL cd_value_zero got=%h exp=%h", d, 32'd0); end
    rd(A_STATUS0, d); n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL cd_status_pre got=%h exp=%h", d, 32'd0); end
    n_vec++; if (irq !== 2'b00) begin n_err++; $display("FAIL cd_irq_pre got=%b exp=%b", irq, 2'b00); end
    cyc(1);
    rd(A_STATUS0, d); n_vec++; if (d !== 32'd1) begin n_err++; $display("FAIL cd_ov_set got=%h exp=%h", d, 32'd1); end
    rd(A_VALUE0, d);  n_vec++; if (d !== 32'd5) begin n_err++; $display("FAIL cd_reload got=%h exp=%h", d, 32'd5); end
    n_vec++; if (irq !== 2'b01) begin n_err++; $display("FAIL cd_irq got=%b exp=%b", irq, 2'b01); end
  endtask

  // Continues: next timeout at P0+48 with OV still set.
  task automatic test_second_stage();
    logic [31:0] d;
    wr(A_CTRL0, 32'd7);
    n_vec++; if (rst_req !== 1'b0) begin n_err++; $display("FAIL ss_rst_req_early got=%b exp=%b", rst_req, 1'b0); end
    cyc(21);
    rd(A_VALUE0, d);  n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL ss_value_zero got=%h exp=%h", d, 32'd0); end
    n_vec++; if (rst_req !== 1'b0) begin n_err++; $display("FAIL ss_rst_req_pre got=%b exp=%b", rst_req, 1'b0); end
    cyc(1);
    rd(A_STATUS0, d); n_vec++; if (d !== 32'd3) begin n_err++; $display("FAIL ss_rstflg got=%h exp=%h", d, 32'd3); end
    n_vec++; if (rst_req !== 1'b1) begin n_err++; $display("FAIL ss_rst_req got=%b exp=%b", rst_req, 1'b1); end
    wr(A_STATUS0, 32'd1);
    rd(A_STATUS0, d); n_vec++; if (d !== 32'd2) begin n_err++; $display("FAIL ss_w1c got=%h exp=%h", d, 32'd2); end
    n_vec++; if (rst_req !== 1'b1) begin n_err++; $display("FAIL ss_rst_req_sticky got=%b exp=%b", rst_req, 1'b1); end
    n_vec++; if (irq !== 2'b00) begin n_err++; $display("FAIL ss_irq_cleared got=%b exp=%b", irq, 2'b00); end
    do_reset();
    n_vec++; if (rst_req !== 1'b0) begin n_err++; $display("FAIL ss_rst_req_reset got=%b exp=%b", rst_req, 1'b0); end
    rd(A_STATUS0, d); n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL ss_status_reset got=%h exp=%h", d, 32'd0); end
  endtask

  // Kick lands exactly on the zero-tick edge (P0+12).
  task automatic test_kick();
    logic [31:0] d;
    wr(A_LOAD0, 32'd2);
    wr(A_PRESC, 32'd3);
    wr(A_CTRL0, 32'd1);
    wr(A_LOAD0, 32'd7);
    rd(A_VALUE0, d);  n_vec++; if (d !== 32'd1) begin n_err++; $display("FAIL kk_load_no_effect got=%h exp=%h", d, 32'd1); end
    rd(A_LOAD0, d);   n_vec++; if (d !== 32'd7) begin n_err++; $display("FAIL kk_load_written got=%h exp=%h", d, 32'd7); end
    cyc(6);
    rd(A_VALUE0, d);  n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL kk_value_zero got=%h exp=%h", d, 32'd0); end
    wr(A_KICK0, KEY);
    rd(A_VALUE0, d);  n_vec++; if (d !== 32'd7) begin n_err++; $display("FAIL kk_reload got=%h exp=%h", d, 32'd7); end
    rd(A_STATUS0, d); n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL kk_no_ov got=%h exp=%h", d, 32'd0); end
    cyc(4);
    rd(A_VALUE0, d);  n_vec++; if (d !== 32'd6) begin n_err++; $display("FAIL kk_count6 got=%h exp=%h", d, 32'd6); end
    wr(A_KICK0, 32'h12345678);
    rd(A_VALUE0, d);  n_vec++; if (d !== 32'd6) begin n_err++; $display("FAIL kk_bad_key got=%h exp=%h", d, 32'd6); end
  endtask

  task automatic test_lock();
    logic [31:0] d;
    wr(A_LOCK, 32'h0);
    rd(A_LOCK, d);    n_vec++; if (d !== 32'd1) begin n_err++; $display("FAIL lk_locked got=%h exp=%h", d, 32'd1); end
    wr(A_LOAD0, 32'd10);
    rd(A_LOAD0, d);   n_vec++; if (d !== 32'd7) begin n_err++; $display("FAIL lk_load_blocked got=%h exp=%h", d, 32'd7); end
    wr(A_CTRL0, 32'd0);
    rd(A_CTRL0, d);   n_vec++; if (d !== 32'd1) begin n_err++; $display("FAIL lk_ctrl_blocked got=%h exp=%h", d, 32'd1); end
    wr(A_PRESC, 32'd5);
    rd(A_PRESC, d);   n_vec++; if (d !== 32'd3) begin n_err++; $display("FAIL lk_presc_blocked got=%h exp=%h", d, 32'd3); end
    wr(A_KICK0, KEY);
    rd(A_VALUE0, d);  n_vec++; if (d !== 32'd7) begin n_err++; $display("FAIL lk_kick_locked got=%h exp=%h", d, 32'd7); end
    wr(A_LOCK, UNLOCK);
    rd(A_LOCK, d);    n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL lk_unlocked got=%h exp=%h", d, 32'd0); end
    wr(A_LOAD0, 32'd10);
    rd(A_LOAD0, d);   n_vec++; if (d !== 32'd10) begin n_err++; $display("FAIL lk_load_ok got=%h exp=%h", d, 32'd10); end
  endtask

  // PRESC=1: ticks every other edge; both W1C writes coincide with timeouts.
  task automatic test_simultaneous();
    logic [31:0] d;
    do_reset();
    wr(A_LOAD0, 32'd0);
    wr(A_PRESC, 32'd1);
    wr(A_CTRL0, 32'd1);
    wr(A_STATUS0, 32'd1);
    rd(A_STATUS0, d); n_vec++; if (d !== 32'd1) begin n_err++; $display("FAIL sim_w1c_vs_first got=%h exp=%h", d, 32'd1); end
    n_vec++; if (irq !== 2'b00) begin n_err++; $display("FAIL sim_irq_masked got=%b exp=%b", irq, 2'b00); end
    wr(A_STATUS0, 32'd1);
    rd(A_STATUS0, d); n_vec++; if (d !== 32'd2) begin n_err++; $display("FAIL sim_w1c_vs_second got=%h exp=%h", d, 32'd2); end
    n_vec++; if (rst_req !== 1'b0) begin n_err++; $display("FAIL sim_rsten_off got=%b exp=%b", rst_req, 1'b0); end
  endtask

  task automatic test_reset_mid_count();
    logic [31:0] d;
    do_reset();
    wr(A_LOAD0, 32'd0);
    wr(A_CTRL0, 32'd3);
    rd(A_STATUS0, d); n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL rm_status0 got=%h exp=%h", d, 32'd0); end
    cyc(1);
    rd(A_STATUS0, d); n_vec++; if (d !== 32'd1) begin n_err++; $display("FAIL rm_load0_tick1 got=%h exp=%h", d, 32'd1); end
    cyc(1);
    rd(A_STATUS0, d); n_vec++; if (d !== 32'd3) begin n_err++; $display("FAIL rm_load0_tick2 got=%h exp=%h", d, 32'd3); end
    wr(A_LOAD0, 32'd9);
    wr(A_KICK0, KEY);
    cyc(6);
    rd(A_VALUE0, d);  n_vec++; if (d !== 32'd3) begin n_err++; $display("FAIL rm_value3 got=%h exp=%h", d, 32'd3); end
    n_vec++; if (irq !== 2'b01) begin n_err++; $display("FAIL rm_irq_pre got=%b exp=%b", irq, 2'b01); end
    #1;
    rst = 1'b1;
    #1;
    rd(A_VALUE0, d);  n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL rm_value_cleared got=%h exp=%h", d, 32'd0); end
    rd(A_STATUS0, d); n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL rm_status_cleared got=%h exp=%h", d, 32'd0); end
    rd(A_CTRL0, d);   n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL rm_ctrl_cleared got=%h exp=%h", d, 32'd0); end
    n_vec++; if (irq !== 2'b00) begin n_err++; $display("FAIL rm_irq_cleared got=%b exp=%b", irq, 2'b00); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_countdown();
    test_second_stage();
    test_kick();
    test_lock();
    test_simultaneous();
    test_reset_mid_count();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
